// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared constants and types for the banked single-port synchronous memory.
//   MACRO_DEPTH / MACRO_WIDTH / MACRO_AW : geometry of one SRAM1RW1024x8 macro
//   state_e                              : controller state (INIT sweep, RUN)
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MACRO_DEPTH = 1024;
  localparam int MACRO_WIDTH = 8;
  localparam int MACRO_AW    = 10;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/SRAM1RW1024x8.sv
// ---------------------------------------------------------------------------
// SRAM1RW1024x8
// Behavioural model of the 1024 x 8 single-port SRAM macro.
//   CE  : clock, rising edge
//   CSB : chip select, active low
//   WEB : write enable, active low (high with CSB low = read)
//   A   : word address
//   I   : write data
//   O   : read data, registered, valid the cycle after a read, held otherwise
// ---------------------------------------------------------------------------
module SRAM1RW1024x8 (
  input  logic       CE,
  input  logic       CSB,
  input  logic       WEB,
  input  logic [9:0] A,
  input  logic [7:0] I,
  output logic [7:0] O
);

  logic [7:0] memArray [0:1023];

  // Writes do not disturb O, so the last read value stays on the output
  always_ff @(posedge CE) begin
    if (!CSB) begin
      if (!WEB) begin
        memArray[A] <= I;
      end else begin
        O <= memArray[A];
      end
    end
  end

endmodule

// File: rtl/mem_bank.sv
// ---------------------------------------------------------------------------
// mem_bank
// One 1024-row bank made of NLANE byte-wide macros side by side.
//   clk     : clock
//   i_csb   : bank chip select, active low, shared by every lane
//   i_web   : per-lane write enable, active low
//   i_addr  : row address, shared by every lane
//   i_wdata : write word, lane n takes bits [8n+7:8n]
//   o_rdata : concatenated lane read data
// ---------------------------------------------------------------------------
module mem_bank
  import mem_pkg::*;
#(
  parameter int NLANE = 4
) (
  input  logic                         clk,
  input  logic                         i_csb,
  input  logic [NLANE-1:0]             i_web,
  input  logic [MACRO_AW-1:0]          i_addr,
  input  logic [NLANE*MACRO_WIDTH-1:0] i_wdata,
  output logic [NLANE*MACRO_WIDTH-1:0] o_rdata
);

  for (genvar lane = 0; lane < NLANE; lane++) begin : gLane
    SRAM1RW1024x8 uMacro (
      .CE  (clk),
      .CSB (i_csb),
      .WEB (i_web[lane]),
      .A   (i_addr),
      .I   (i_wdata[lane*MACRO_WIDTH +: MACRO_WIDTH]),
      .O   (o_rdata[lane*MACRO_WIDTH +: MACRO_WIDTH])
    );
  end

endmodule

// File: rtl/mem_sync_sp_bank.sv
// ---------------------------------------------------------------------------
// mem_sync_sp_bank
// Single-port synchronous memory of DEPTH words x DATA_WIDTH bits built from
// NBANK x NLANE SRAM1RW1024x8 macros, with an optional zeroing sweep after
// reset. One request per cycle, read data one cycle after acceptance.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   i_req       : request valid, accepted when i_req && o_ready
//   o_ready     : high once the memory is usable
//   i_addr      : word address
//   i_wdata     : write data
//   i_wen       : byte-lane write enables, all zero = read
//   o_rdata     : read data, held between reads
//   o_rvalid    : one-cycle strobe per accepted read
//   o_err       : one-cycle strobe per accepted out-of-range request
//   o_init_done : high in RUN
// ---------------------------------------------------------------------------
module mem_sync_sp_bank
  import mem_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int INIT_ZERO  = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_req,
  output logic                    o_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wen,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_err,
  output logic                    o_init_done
);

  localparam int NBANK  = DEPTH / MACRO_DEPTH;
  localparam int NLANE  = DATA_WIDTH / MACRO_WIDTH;
  // A single-bank memory has no bank bits, keep a 1-bit index anyway
  localparam int BANK_W = (ADDR_WIDTH > MACRO_AW) ? ADDR_WIDTH - MACRO_AW : 1;
  // DEPTH itself may not fit in ADDR_WIDTH bits, so compare one bit wider
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam state_e RESET_STATE = (INIT_ZERO != 0) ? INIT : RUN;

  state_e                  state_q, state_d;
  logic [MACRO_AW-1:0]     row_q, row_d;
  logic [BANK_W-1:0]       bank_q;
  logic                    rvalid_q;
  logic                    err_q;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;

  logic [BANK_W-1:0]       req_bank;
  logic [MACRO_AW-1:0]     req_row;
  logic                    in_range;
  logic                    accept;
  logic                    read_acc;

  logic [NBANK-1:0]        bank_csb;
  logic [NLANE-1:0]        bank_web;
  logic [MACRO_AW-1:0]     bank_addr;
  logic [DATA_WIDTH-1:0]   bank_wdata;
  logic [DATA_WIDTH-1:0]   bank_rdata [NBANK];
  logic [DATA_WIDTH-1:0]   read_word;

  assign req_bank = BANK_W'(i_addr >> MACRO_AW);
  assign req_row  = i_addr[MACRO_AW-1:0];
  assign in_range = ({1'b0, i_addr} < DEPTH_L);
  assign accept   = i_req && o_ready;
  assign read_acc = accept && (i_wen == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && row_q == MACRO_AW'(MACRO_DEPTH - 1)) begin
      state_d = RUN;
    end
  end

  // ---------------- FSM: outputs ----------------
  // Gated with rst_n so a RUN reset state still shows not-ready during reset
  always_comb begin
    o_ready     = rst_n && (state_q == RUN);
    o_init_done = rst_n && (state_q == RUN);
  end

  // Sweep row counter, wraps back to 0 as the FSM leaves INIT
  always_comb begin
    row_d = row_q;
    if (state_q == INIT) begin
      row_d = row_q + MACRO_AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  // Macro control: the sweep writes zero everywhere at once; in RUN only
  // the addressed bank is selected, and never for an out-of-range address
  always_comb begin
    bank_csb   = '1;
    bank_web   = '1;
    bank_addr  = req_row;
    bank_wdata = i_wdata;
    if (state_q == INIT) begin
      bank_csb   = '0;
      bank_web   = '0;
      bank_addr  = row_q;
      bank_wdata = '0;
    end else if (accept && in_range) begin
      bank_web = ~i_wen;
      for (int b = 0; b < NBANK; b++) begin
        if (req_bank == BANK_W'(b)) begin
          bank_csb[b] = 1'b0;
        end
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : gBank
    mem_bank #(
      .NLANE (NLANE)
    ) uBank (
      .clk     (clk),
      .i_csb   (bank_csb[b]),
      .i_web   (bank_web),
      .i_addr  (bank_addr),
      .i_wdata (bank_wdata),
      .o_rdata (bank_rdata[b])
    );
  end

  // Response pipeline: the bank index is captured with the request so the
  // read mux does not depend on whatever address is presented next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      bank_q   <= '0;
    end else begin
      rvalid_q <= read_acc;
      err_q    <= accept && !in_range;
      if (accept) begin
        bank_q <= req_bank;
      end
    end
  end

  // Read mux; an out-of-range read returns zero
  always_comb begin
    read_word = '0;
    if (!err_q) begin
      for (int b = 0; b < NBANK; b++) begin
        if (bank_q == BANK_W'(b)) begin
          read_word = bank_rdata[b];
        end
      end
    end
  end

  // Hold register: the output follows the macros only on the strobe cycle
  always_comb begin
    hold_d = hold_q;
    if (rvalid_q) begin
      hold_d = read_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign o_rdata  = hold_d;
  assign o_rvalid = rvalid_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_mem_sync_sp_bank.sv
// ---------------------------------------------------------------------------
// tb_mem_sync_sp_bank
// Directed bench for a 3072 x 32 instance with the zeroing sweep enabled.
// Expected responses are queued as requests are issued; a negedge monitor
// pops and compares every o_rvalid / o_err strobe.
// ---------------------------------------------------------------------------
module tb_mem_sync_sp_bank;

  localparam int DEPTH = 3072;
  localparam int DW    = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          rvalid;
    logic          err;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          req = 1'b0;
  logic          ready;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NW-1:0] wen = '0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;
  logic          initDone;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycles;

  mem_sync_sp_bank #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW),
    .INIT_ZERO  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .i_req       (req),
    .o_ready     (ready),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_wen       (wen),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_err       (err),
    .o_init_done (initDone)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, returns #1 after the capturing edge
  task automatic applyStimulus(input logic r, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [NW-1:0] w);
    req   = r;
    addr  = a;
    wdata = d;
    wen   = w;
    @(posedge clk);
    #1;
  endtask

  task automatic issueRead(input logic [AW-1:0] a, input logic [DW-1:0] expData,
                           input logic expErr);
    exp_t e;
    e.data = expData; e.rvalid = 1'b1; e.err = expErr; e.addr = a;
    expQ.push_back(e);
    applyStimulus(1'b1, a, '0, '0);
  endtask

  task automatic issueWrite(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NW-1:0] w, input logic expErr);
    exp_t e;
    if (expErr) begin
      e.data = '0; e.rvalid = 1'b0; e.err = 1'b1; e.addr = a;
      expQ.push_back(e);
    end
    applyStimulus(1'b1, a, d, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, '0, '0, '0);
    end
  endtask

  // Counts rising edges from reset release until o_ready, bounded
  task automatic waitReady(output int n);
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstN && (rvalid || err)) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected strobe: got rvalid=%0b err=%0b rdata=0x%08h, expected none",
                 rvalid, err, rdata);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("strobes@%03h", e.addr), DW'({rvalid, err}),
                    DW'({e.rvalid, e.err}));
        if (e.rvalid) begin
          checkOutput($sformatf("rdata@%03h", e.addr), rdata, e.data);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset ready", DW'(ready), 0);
    checkOutput("reset init_done", DW'(initDone), 0);
    checkOutput("reset rvalid", DW'(rvalid), 0);
    checkOutput("reset err", DW'(err), 0);
    checkOutput("reset rdata", rdata, 0);

    // Sweep interrupted at row 500, requests during INIT must be ignored
    rstN = 1'b1;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b1, AW'(i), 32'h5555_5555, (i % 2 == 0) ? 4'h0 : 4'hF);
    end
    req = 1'b0;
    checkOutput("ready mid-sweep", DW'(ready), 0);
    rstN = 1'b0;
    #1;
    checkOutput("ready in reset", DW'(ready), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    waitReady(cycles);
    checkOutput("sweep cycles", DW'(cycles), 1024);
    checkOutput("init_done after sweep", DW'(initDone), 1);

    // Zeroed contents
    issueRead(12'h7FF, 32'h0000_0000, 1'b0);
    issueRead(12'hBFF, 32'h0000_0000, 1'b0);

    // Write then back-to-back reads, including read-after-write
    issueWrite(12'h000, 32'hDEAD_BEEF, 4'hF, 1'b0);
    issueRead(12'h400, 32'h0000_0000, 1'b0);
    issueRead(12'h000, 32'hDEAD_BEEF, 1'b0);

    // Byte-lane merge
    issueWrite(12'h010, 32'h1122_3344, 4'hF, 1'b0);
    issueWrite(12'h010, 32'hAABB_CCDD, 4'b0101, 1'b0);
    issueRead(12'h010, 32'h11BB_33DD, 1'b0);

    // Out of range read and write, memory untouched
    issueRead(12'hC00, 32'h0000_0000, 1'b1);
    issueWrite(12'hC00, 32'hFFFF_FFFF, 4'hF, 1'b1);
    issueWrite(12'hFFF, 32'hFFFF_FFFF, 4'hF, 1'b1);
    issueRead(12'h000, 32'hDEAD_BEEF, 1'b0);
    issueRead(12'h800, 32'h0000_0000, 1'b0);
    issueRead(12'h3FF, 32'h0000_0000, 1'b0);

    // Hold register across idle cycles and an unrelated partial write
    issueWrite(12'h005, 32'hCAFE_F00D, 4'hF, 1'b0);
    issueRead(12'h005, 32'hCAFE_F00D, 1'b0);
    idle(1);
    checkOutput("hold idle 1 rdata", rdata, 32'hCAFE_F00D);
    checkOutput("hold idle 1 rvalid", DW'(rvalid), 0);
    idle(1);
    checkOutput("hold idle 2 rdata", rdata, 32'hCAFE_F00D);
    issueWrite(12'h006, 32'h1234_5678, 4'b0011, 1'b0);
    req = 1'b0;
    checkOutput("hold after write", rdata, 32'hCAFE_F00D);
    idle(1);
    issueRead(12'h006, 32'h0000_5678, 1'b0);
    idle(2);

    // Reset with a read in flight: no strobe, outputs cleared at once
    applyStimulus(1'b1, 12'h000, '0, '0);
    req  = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("in-flight reset rvalid", DW'(rvalid), 0);
    checkOutput("in-flight reset rdata", rdata, 0);
    checkOutput("in-flight reset ready", DW'(ready), 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    waitReady(cycles);
    checkOutput("second sweep cycles", DW'(cycles), 1024);
    issueRead(12'h000, 32'h0000_0000, 1'b0);
    issueRead(12'h010, 32'h0000_0000, 1'b0);
    idle(3);

    checkOutput("scoreboard drained", DW'(expQ.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_sync_sp_bank.md
MEM_SYNC_SP_BANK -- requirements
Module: mem_sync_sp_bank

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2048, total words; a multiple of 1024 is required.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, word width in bits; a multiple of 8 is required.
REQ-003 The module SHALL have parameter INIT_ZERO, default 1; 1 = zero all words after reset, 0 = skip the sweep.
REQ-004 The module SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port i_req, input, 1 bit: request valid.
REQ-008 The module SHALL have port o_ready, output, 1 bit: request accepted when i_req && o_ready.
REQ-009 The module SHALL have ports i_addr, input, ADDR_WIDTH; i_wdata, input, DATA_WIDTH; i_wen, input, DATA_WIDTH/8: byte-lane write enables, all-zero = read.
REQ-010 The module SHALL have ports o_rdata, output, DATA_WIDTH: read data; o_rvalid, output, 1 bit: read-data strobe.
REQ-011 The module SHALL have ports o_err, output, 1 bit: out-of-range strobe; o_init_done, output, 1 bit: memory usable.

Function
REQ-012 Storage SHALL tile SRAM1RW1024x8 macros as NBANK = DEPTH/1024 banks by NLANE = DATA_WIDTH/8 lanes; bank = i_addr / 1024, row = i_addr % 1024.
REQ-013 An accepted request SHALL assert CSB only in the selected bank, with WEB low per lane where i_wen is set; unselected banks see CSB high.
REQ-014 An accepted read SHALL drive o_rvalid high exactly one cycle later, with o_rdata muxed by a registered bank index, not the current i_addr.
REQ-015 o_rdata SHALL hold the last read value in a hold register until the next o_rvalid; writes and idle cycles SHALL NOT change it.
REQ-016 An accepted write SHALL update only the enabled byte lanes and SHALL NOT assert o_rvalid.
REQ-017 A read accepted the cycle after a write to the same address SHALL return the newly written bytes.
REQ-018 Back-to-back requests SHALL be accepted every cycle while o_ready is high, giving a throughput of one per cycle.
REQ-019 An address >= DEPTH (possible when NBANK is not a power of two) SHALL be accepted with no macro access; o_err SHALL pulse one cycle later, and a read SHALL also pulse o_rvalid with o_rdata = 0.
REQ-020 The FSM SHALL have states INIT and RUN: reset enters INIT if INIT_ZERO = 1, else RUN.
REQ-021 In INIT, a 10-bit row counter SHALL step 0..1023, writing zero to all banks and lanes each cycle; after row 1023 the FSM SHALL go to RUN. The sweep takes 1024 cycles.
REQ-022 o_ready SHALL be low in INIT and high in RUN; o_init_done SHALL equal (state == RUN).
REQ-023 i_req during INIT SHALL be ignored, with no side effects.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear o_ready, o_rvalid, o_err, o_init_done, o_rdata (0), the row counter (0) and the registered bank index (0).
REQ-025 On reset release the FSM SHALL start in INIT at row 0 (INIT_ZERO = 1) or in RUN (INIT_ZERO = 0).
REQ-026 Reset asserted mid-sweep SHALL restart the sweep from row 0; a read in flight at reset SHALL produce no o_rvalid.

Structure
REQ-027 Package mem_pkg SHALL hold MACRO_DEPTH = 1024, MACRO_WIDTH = 8, and the state enum {INIT, RUN}.
REQ-028 Sub-module mem_bank SHALL contain one bank of NLANE macros with its CSB/WEB/address/data fan-out; the top SHALL generate NBANK instances.
REQ-029 The top SHALL contain the FSM, init counter, bank-select register, read mux, hold register and range check.

Verification
REQ-030 INIT_ZERO = 1, DEPTH = 2048, DATA_WIDTH = 32: release reset, then o_ready stays low for 1024 cycles and goes high at cycle 1025; a read of 0x7FF then returns 0x00000000.
REQ-031 Write 0xDEADBEEF with i_wen = 4'hF to 0x000, then read 0x400 and 0x000 on consecutive cycles: o_rdata = 0x00000000, then 0xDEADBEEF, on consecutive o_rvalid cycles.
REQ-032 Write 0x11223344 to 0x010, then write 0xAABBCCDD with i_wen = 4'b0101, then read: o_rdata = 0x11BB33DD.
REQ-033 DEPTH = 3072: read address 0xC00 -> o_err and o_rvalid pulse together with o_rdata = 0; memory contents are unchanged.
REQ-034 Drop rst_n at sweep row 500, then release: the sweep restarts from row 0, and o_ready rises 1024 cycles after release.
REQ-035 Read 0x005 followed by two idle cycles: o_rdata holds its value and o_rvalid is high for exactly one cycle.
